// File: rtl/zip_mem_pkg.sv
// Shared encodings for the ZipCPU memory unit: operand sizes, FSM states
// and the alignment rule.
package zip_mem_pkg;

   typedef enum logic [1:0] {
      OP_RSVD = 2'b00,
      OP_WORD = 2'b01,
      OP_HALF = 2'b10,
      OP_BYTE = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } mem_state_t;

   // The reserved size code is handled exactly like a word access.
   function automatic logic misaligned(input mem_size_t sz, input logic [1:0] a);
      case (sz)
         OP_BYTE: misaligned = 1'b0;
         OP_HALF: misaligned = a[0];
         default: misaligned = (a != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/zip_wb_memunit_if.sv
// Pipelined Wishbone bus seen from the memory unit (master) and the
// memory/interconnect (slave).
interface zip_wb_memunit_if #(
   parameter int AW = 30
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] addr;
   logic [31:0]   data;
   logic [3:0]    sel;
   logic          stall;
   logic          ack;
   logic          err;
   logic [31:0]   idata;

   modport master (
      output cyc, stb, we, addr, data, sel,
      input  stall, ack, err, idata
   );

   modport slave (
      input  cyc, stb, we, addr, data, sel,
      output stall, ack, err, idata
   );
endinterface

// File: rtl/zip_memunit_lanes.sv
// Big-endian byte-lane steering: select mask and store replication for a
// request, plus shift-down and zero-extension of returned load data.
module zip_memunit_lanes
   import zip_mem_pkg::*;
(
   input  mem_size_t   i_size,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_data,
   input  mem_size_t   i_rd_size,
   input  logic [1:0]  i_rd_off,
   input  logic [31:0] i_rd_data,
   output logic [3:0]  o_sel,
   output logic [31:0] o_data,
   output logic [31:0] o_rd_data
);

   // Lane gi carries bits [8*gi+7:8*gi]; byte offset 0 lives in lane 3.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE_OFF = 2'(3 - gi);

         assign o_sel[gi] = (i_size == OP_BYTE) ? (i_off == LANE_OFF)
                          : (i_size == OP_HALF) ? (i_off[1] == LANE_OFF[1])
                          : 1'b1;

         assign o_data[8*gi +: 8] = (i_size == OP_BYTE) ? i_data[7:0]
                                  : (i_size == OP_HALF) ? i_data[8*(gi%2) +: 8]
                                  : i_data[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      o_rd_data = '0;
      case (i_rd_size)
         OP_BYTE: begin
            case (i_rd_off)
               2'd0:    o_rd_data[7:0] = i_rd_data[31:24];
               2'd1:    o_rd_data[7:0] = i_rd_data[23:16];
               2'd2:    o_rd_data[7:0] = i_rd_data[15:8];
               default: o_rd_data[7:0] = i_rd_data[7:0];
            endcase
         end
         OP_HALF: o_rd_data[15:0] = i_rd_off[1] ? i_rd_data[15:0] : i_rd_data[31:16];
         default: o_rd_data = i_rd_data;
      endcase
   end

endmodule

// File: rtl/zip_wb_memunit.sv
// ZipCPU memory unit: one load/store at a time, issued as a single pipelined
// Wishbone transfer, with the busy/valid/done/err handshake to the pipeline.
module zip_wb_memunit
   import zip_mem_pkg::*;
#(
   parameter bit IMPLEMENT_LOCK    = 1'b0,
   parameter bit OPT_ALIGNMENT_ERR = 1'b1,
   parameter int AW                = 30
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_cpu_reset,
   input  logic        i_stb,
   input  logic        i_lock,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data,
   input  logic [4:0]  i_oreg,
   output logic        o_busy,
   output logic        o_rdbusy,
   output logic        o_pipe_stalled,
   output logic        o_valid,
   output logic        o_done,
   output logic        o_err,
   output logic [4:0]  o_wreg,
   output logic [31:0] o_result,
   zip_wb_memunit_if.master wb
);

   mem_state_t    state_reg,  state_next;
   logic          cyc_reg,    cyc_next;
   logic          stb_reg,    stb_next;
   logic          we_reg,     we_next;
   logic [AW-1:0] addr_reg,   addr_next;
   logic [31:0]   wdata_reg,  wdata_next;
   logic [3:0]    sel_reg,    sel_next;
   mem_size_t     size_reg,   size_next;
   logic [1:0]    off_reg,    off_next;
   logic [4:0]    wreg_reg,   wreg_next;
   logic [31:0]   result_reg, result_next;
   logic          valid_reg,  valid_next;
   logic          done_reg,   done_next;
   logic          err_reg,    err_next;

   mem_size_t   req_size;
   logic [3:0]  lane_sel;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;

   assign req_size = mem_size_t'(i_op[2:1]);

   zip_memunit_lanes u_lanes (
      .i_size    (req_size),
      .i_off     (i_addr[1:0]),
      .i_data    (i_data),
      .i_rd_size (size_reg),
      .i_rd_off  (off_reg),
      .i_rd_data (wb.idata),
      .o_sel     (lane_sel),
      .o_data    (lane_wdata),
      .o_rd_data (lane_rdata)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg  <= ST_IDLE;
         cyc_reg    <= 1'b0;
         stb_reg    <= 1'b0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         sel_reg    <= '0;
         size_reg   <= OP_RSVD;
         off_reg    <= '0;
         wreg_reg   <= '0;
         result_reg <= '0;
         valid_reg  <= 1'b0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cyc_reg    <= cyc_next;
         stb_reg    <= stb_next;
         we_reg     <= we_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         sel_reg    <= sel_next;
         size_reg   <= size_next;
         off_reg    <= off_next;
         wreg_reg   <= wreg_next;
         result_reg <= result_next;
         valid_reg  <= valid_next;
         done_reg   <= done_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cyc_next    = cyc_reg;
      stb_next    = stb_reg;
      we_next     = we_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      sel_next    = sel_reg;
      size_next   = size_reg;
      off_next    = off_reg;
      wreg_next   = wreg_reg;
      result_next = result_reg;
      valid_next  = 1'b0;
      done_next   = 1'b0;
      err_next    = 1'b0;

      if (i_cpu_reset) begin
         // Abort: the aborted op never reports, and a late ack lands in IDLE.
         state_next  = ST_IDLE;
         cyc_next    = 1'b0;
         stb_next    = 1'b0;
         we_next     = 1'b0;
         addr_next   = '0;
         wdata_next  = '0;
         sel_next    = '0;
         size_next   = OP_RSVD;
         off_next    = '0;
         wreg_next   = '0;
         result_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               // A locked sequence keeps the bus owned between operations.
               cyc_next = IMPLEMENT_LOCK && cyc_reg && i_lock;
               stb_next = 1'b0;
               if (i_stb) begin
                  wreg_next = i_oreg;
                  if (OPT_ALIGNMENT_ERR && misaligned(req_size, i_addr[1:0])) begin
                     done_next = 1'b1;
                     err_next  = 1'b1;
                     cyc_next  = 1'b0;
                  end else begin
                     state_next = ST_REQ;
                     cyc_next   = 1'b1;
                     stb_next   = 1'b1;
                     we_next    = i_op[0];
                     addr_next  = i_addr[AW+1:2];
                     wdata_next = lane_wdata;
                     sel_next   = lane_sel;
                     size_next  = req_size;
                     off_next   = i_addr[1:0];
                  end
               end
            end
            ST_REQ, ST_ACK: begin
               if (wb.err) begin
                  state_next = ST_IDLE;
                  cyc_next   = 1'b0;
                  stb_next   = 1'b0;
                  done_next  = 1'b1;
                  err_next   = 1'b1;
               end else if (wb.ack) begin
                  state_next = ST_IDLE;
                  cyc_next   = IMPLEMENT_LOCK && i_lock;
                  stb_next   = 1'b0;
                  done_next  = 1'b1;
                  valid_next = !we_reg;
                  if (!we_reg)
                     result_next = lane_rdata;
               end else if ((state_reg == ST_REQ) && !wb.stall) begin
                  state_next = ST_ACK;
                  stb_next   = 1'b0;
               end
            end
            default: begin
               state_next = ST_IDLE;
               cyc_next   = 1'b0;
               stb_next   = 1'b0;
            end
         endcase
      end
   end

   assign o_busy         = (state_reg != ST_IDLE);
   assign o_pipe_stalled = o_busy;
   assign o_rdbusy       = o_busy && !we_reg;
   assign o_valid        = valid_reg;
   assign o_done         = done_reg;
   assign o_err          = err_reg;
   assign o_wreg         = wreg_reg;
   assign o_result       = result_reg;

   assign wb.cyc  = cyc_reg;
   assign wb.stb  = stb_reg;
   assign wb.we   = we_reg;
   assign wb.addr = addr_reg;
   assign wb.data = wdata_reg;
   assign wb.sel  = sel_reg;

endmodule

// File: tb/tb_zip_wb_memunit.sv
// Self-checking bench for zip_wb_memunit: directed scenarios plus randomized
// loads/stores against an arithmetic byte-lane model and a Wishbone slave.
module tb_zip_wb_memunit;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_cpu_reset;
   logic        i_stb;
   logic        i_lock;
   logic [2:0]  i_op;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic [4:0]  i_oreg;
   logic        o_busy, o_rdbusy, o_pipe_stalled, o_valid, o_done, o_err;
   logic [4:0]  o_wreg;
   logic [31:0] o_result;

   int n_cmp  = 0;
   int n_fail = 0;

   zip_wb_memunit_if #(.AW(30)) bus ();

   zip_wb_memunit #(
      .IMPLEMENT_LOCK    (1'b1),
      .OPT_ALIGNMENT_ERR (1'b1),
      .AW                (30)
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_cpu_reset    (i_cpu_reset),
      .i_stb          (i_stb),
      .i_lock         (i_lock),
      .i_op           (i_op),
      .i_addr         (i_addr),
      .i_data         (i_data),
      .i_oreg         (i_oreg),
      .o_busy         (o_busy),
      .o_rdbusy       (o_rdbusy),
      .o_pipe_stalled (o_pipe_stalled),
      .o_valid        (o_valid),
      .o_done         (o_done),
      .o_err          (o_err),
      .o_wreg         (o_wreg),
      .o_result       (o_result),
      .wb             (bus.master)
   );

   always #5 i_clk = ~i_clk;

   localparam logic [2:0] LW = 3'b010, SW = 3'b011, LH = 3'b100;
   localparam logic [2:0] SH = 3'b101, LB = 3'b110, SB = 3'b111;

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b11) ? 1 : (sz == 2'b10) ? 2 : 4;
   endfunction

   function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
      int off = int'(a[1:0]);
      return (off % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      int off = int'(a[1:0]);
      return 4'(((1 << n) - 1) << (4 - off - n));
   endfunction

   function automatic logic [31:0] m_wdat(input logic [1:0] sz, input logic [31:0] d);
      int n = nbytes(sz);
      if (n == 1) return {4{d[7:0]}};
      if (n == 2) return {2{d[15:0]}};
      return d;
   endfunction

   function automatic logic [31:0] m_result(input logic [1:0] sz, input logic [31:0] a,
                                            input logic [31:0] r);
      int n = nbytes(sz);
      int off = int'(a[1:0]);
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
      return (r >> (8 * (4 - off - n))) & mask;
   endfunction

   // ---------------- stimulus driver + slave model ----------------
   logic [5:0]  obs_req;   // {cyc,stb,we,busy,rdbusy,pipe_stalled} first bus cycle
   logic [3:0]  obs_sel;
   logic [29:0] obs_adr;
   logic [31:0] obs_wdat;
   int          obs_hold_bad;
   logic [4:0]  obs_rsp;   // {done,valid,err,busy,cyc} cycle after ack/err
   logic [31:0] obs_result;
   logic [4:0]  obs_wreg;
   logic [2:0]  obs_after; // {done,valid,err} one cycle later

   bit watch_cyc = 0;
   int cyc_low_cnt = 0;
   always @(negedge i_clk) if (watch_cyc && bus.cyc !== 1'b1) cyc_low_cnt++;

   task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] oreg, input int stalls, input int ack_dly,
                         input bit berr, input logic [31:0] rdata);
      i_stb = 1'b1; i_op = op; i_addr = addr; i_data = data; i_oreg = oreg;
      @(negedge i_clk);
      i_stb = 1'b0; i_op = 3'($urandom); i_addr = $urandom; i_data = $urandom; i_oreg = 5'($urandom);
      obs_req  = {bus.cyc, bus.stb, bus.we, o_busy, o_rdbusy, o_pipe_stalled};
      obs_sel  = bus.sel;
      obs_adr  = bus.addr;
      obs_wdat = bus.data;
      obs_hold_bad = 0;
      if (bus.stb === 1'b1) begin
         for (int i = 0; i < stalls; i++) begin
            bus.stall = 1'b1;
            @(negedge i_clk);
            if ({bus.stb, bus.addr, bus.data, bus.sel, o_busy} !== {1'b1, obs_adr, obs_wdat, obs_sel, 1'b1})
               obs_hold_bad++;
         end
         bus.stall = 1'b0;
         for (int k = 0; k < ack_dly; k++) begin
            @(negedge i_clk);
            if ({bus.cyc, bus.stb, o_busy} !== 3'b101) obs_hold_bad++;
         end
         bus.ack = !berr; bus.err = berr; bus.idata = rdata;
         @(negedge i_clk);
         bus.ack = 1'b0; bus.err = 1'b0; bus.idata = $urandom;
      end
      obs_rsp    = {o_done, o_valid, o_err, o_busy, bus.cyc};
      obs_result = o_result;
      obs_wreg   = o_wreg;
      @(negedge i_clk);
      obs_after  = {o_done, o_valid, o_err};
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_reset_n = 1'b0; i_cpu_reset = 1'b0; i_stb = 1'b0; i_lock = 1'b0;
      i_op = '0; i_addr = '0; i_data = '0; i_oreg = '0;
      bus.stall = 1'b0; bus.ack = 1'b0; bus.err = 1'b0; bus.idata = '0;
      repeat (3) @(negedge i_clk);
      n_cmp++;
      if ({o_busy, o_rdbusy, o_pipe_stalled, o_valid, o_done, o_err, o_wreg, o_result,
           bus.cyc, bus.stb, bus.we, bus.addr, bus.data, bus.sel} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b cyc=%b stb=%b wreg=%h result=%h sel=%b, required all zero",
                  o_busy, bus.cyc, bus.stb, o_wreg, o_result, bus.sel);
      end
      i_reset_n = 1'b1;
      @(negedge i_clk);
      n_cmp++;
      if ({o_busy, o_done, o_valid, o_err, bus.cyc, bus.stb} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got busy=%b done=%b valid=%b err=%b cyc=%b stb=%b, required zeros",
                  o_busy, o_done, o_valid, o_err, bus.cyc, bus.stb);
      end
   endtask

   task automatic test_load_word();
      run_op(LW, 32'h0000_0100, 32'h0, 5'h15, 0, 1, 1'b0, 32'hDEAD_BEEF);
      $display("txn LW 0x100 sel=%b adr=%h result=%h wreg=%h", obs_sel, obs_adr, obs_result, obs_wreg);
      n_cmp++;
      if (obs_req !== 6'b110111) begin n_fail++; $display("FAIL lw_req_ctl: got %b required %b", obs_req, 6'b110111); end
      n_cmp++;
      if (obs_sel !== 4'b1111) begin n_fail++; $display("FAIL lw_sel: got %b required 1111", obs_sel); end
      n_cmp++;
      if (obs_adr !== 30'h40) begin n_fail++; $display("FAIL lw_addr: got %h required 40", obs_adr); end
      n_cmp++;
      if (obs_rsp !== 5'b11000) begin n_fail++; $display("FAIL lw_rsp: got %b required 11000", obs_rsp); end
      n_cmp++;
      if (obs_result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_result: got %h required deadbeef", obs_result); end
      n_cmp++;
      if (obs_wreg !== 5'h15) begin n_fail++; $display("FAIL lw_wreg: got %h required 15", obs_wreg); end
      n_cmp++;
      if (obs_after !== 3'b000) begin n_fail++; $display("FAIL lw_valid_once: got %b required 000", obs_after); end
   endtask

   task automatic test_lanes();
      run_op(LB, 32'h0000_0103, 32'h0, 5'h03, 0, 0, 1'b0, 32'h1122_3344);
      $display("txn LB 0x103 sel=%b result=%h", obs_sel, obs_result);
      n_cmp++;
      if (obs_sel !== 4'b0001) begin n_fail++; $display("FAIL lb_sel: got %b required 0001", obs_sel); end
      n_cmp++;
      if (obs_result !== 32'h0000_0044) begin n_fail++; $display("FAIL lb_result: got %h required 00000044", obs_result); end
      run_op(SH, 32'h0000_0102, 32'h0000_ABCD, 5'h04, 0, 2, 1'b0, 32'h5555_5555);
      $display("txn SH 0x102 sel=%b wdat=%h rsp=%b", obs_sel, obs_wdat, obs_rsp);
      n_cmp++;
      if (obs_sel !== 4'b0011) begin n_fail++; $display("FAIL sh_sel: got %b required 0011", obs_sel); end
      n_cmp++;
      if (obs_wdat[15:0] !== 16'hABCD) begin n_fail++; $display("FAIL sh_data: got %h required abcd", obs_wdat[15:0]); end
      n_cmp++;
      if (obs_req !== 6'b111101) begin n_fail++; $display("FAIL sh_req_ctl: got %b required 111101", obs_req); end
      n_cmp++;
      if (obs_rsp !== 5'b10000) begin n_fail++; $display("FAIL sh_no_valid: got %b required 10000", obs_rsp); end
   endtask

   task automatic test_stall();
      run_op(LW, 32'h0000_0A00, 32'h0, 5'h09, 4, 1, 1'b0, 32'hCAFE_F00D);
      $display("txn LW 0xa00 stall=4 hold_bad=%0d result=%h", obs_hold_bad, obs_result);
      n_cmp++;
      if (obs_hold_bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles required 0", obs_hold_bad); end
      n_cmp++;
      if (obs_result !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL stall_result: got %h required cafef00d", obs_result); end
   endtask

   task automatic test_bus_err();
      run_op(LW, 32'h0000_0400, 32'h0, 5'h0B, 1, 1, 1'b1, 32'h1234_5678);
      $display("txn LW 0x400 bus error rsp=%b", obs_rsp);
      n_cmp++;
      if (obs_rsp !== 5'b10100) begin n_fail++; $display("FAIL bus_err_rsp: got %b required 10100", obs_rsp); end
      n_cmp++;
      if (obs_after !== 3'b000) begin n_fail++; $display("FAIL bus_err_once: got %b required 000", obs_after); end
   endtask

   task automatic test_align_err();
      run_op(LW, 32'h0000_0102, 32'h0, 5'h0C, 0, 0, 1'b0, 32'h0);
      $display("txn LW 0x102 misaligned rsp=%b", obs_rsp);
      n_cmp++;
      if (obs_rsp !== 5'b10100) begin n_fail++; $display("FAIL align_err_rsp: got %b required 10100", obs_rsp); end
      n_cmp++;
      if ({obs_req[5], obs_req[4], obs_req[2]} !== 3'b000) begin
         n_fail++; $display("FAIL align_no_bus: got cyc/stb/busy=%b required 000", {obs_req[5], obs_req[4], obs_req[2]});
      end
   endtask

   task automatic test_cpu_reset();
      i_stb = 1'b1; i_op = LW; i_addr = 32'h0000_0200; i_oreg = 5'h07;
      @(negedge i_clk);
      i_stb = 1'b0;
      bus.stall = 1'b0;
      @(negedge i_clk);
      n_cmp++;
      if ({bus.cyc, bus.stb, o_busy} !== 3'b101) begin
         n_fail++; $display("FAIL cpurst_in_ack: got cyc/stb/busy=%b required 101", {bus.cyc, bus.stb, o_busy});
      end
      i_cpu_reset = 1'b1;
      @(negedge i_clk);
      i_cpu_reset = 1'b0;
      n_cmp++;
      if ({bus.cyc, bus.stb, o_busy} !== 3'b000) begin
         n_fail++; $display("FAIL cpurst_abort: got cyc/stb/busy=%b required 000", {bus.cyc, bus.stb, o_busy});
      end
      bus.ack = 1'b1; bus.idata = 32'h9999_9999;
      @(negedge i_clk);
      bus.ack = 1'b0;
      n_cmp++;
      if ({o_done, o_valid, o_err, o_wreg, o_result} !== '0) begin
         n_fail++; $display("FAIL cpurst_late_ack: got done/valid/err=%b wreg=%h result=%h required zeros",
                            {o_done, o_valid, o_err}, o_wreg, o_result);
      end
      $display("txn LW 0x200 aborted by cpu reset");
   endtask

   task automatic test_lock();
      i_lock = 1'b1;
      run_op(LW, 32'h0000_0300, 32'h0, 5'h01, 0, 1, 1'b0, 32'h0BAD_F00D);
      n_cmp++;
      if (obs_rsp !== 5'b11001) begin n_fail++; $display("FAIL lock_first_rsp: got %b required 11001", obs_rsp); end
      cyc_low_cnt = 0;
      watch_cyc = 1;
      run_op(SW, 32'h0000_0304, 32'h1357_9BDF, 5'h02, 1, 0, 1'b0, 32'h0);
      watch_cyc = 0;
      n_cmp++;
      if (cyc_low_cnt !== 0) begin n_fail++; $display("FAIL lock_cyc_held: got %0d low cycles required 0", cyc_low_cnt); end
      n_cmp++;
      if (obs_rsp !== 5'b10001) begin n_fail++; $display("FAIL lock_second_rsp: got %b required 10001", obs_rsp); end
      i_lock = 1'b0;
      @(negedge i_clk);
      n_cmp++;
      if (bus.cyc !== 1'b0) begin n_fail++; $display("FAIL lock_release: got cyc=%b required 0", bus.cyc); end
      i_lock = 1'b1;
      run_op(LW, 32'h0000_0308, 32'h0, 5'h03, 0, 0, 1'b1, 32'h0);
      i_lock = 1'b0;
      n_cmp++;
      if (obs_rsp !== 5'b10100) begin n_fail++; $display("FAIL lock_err_drop: got %b required 10100", obs_rsp); end
      $display("txn locked pair 0x300/0x304 then errored locked load");
   endtask

   task automatic test_random();
      for (int t = 0; t < 60; t++) begin
         logic [1:0]  sz    = 2'($urandom_range(1, 3));
         bit          store = 1'($urandom_range(0, 1));
         logic [2:0]  op    = {sz, store};
         logic [31:0] addr  = $urandom;
         logic [31:0] data  = $urandom;
         logic [31:0] rdata = $urandom;
         logic [4:0]  oreg  = 5'($urandom);
         int          stl   = $urandom_range(0, 3);
         int          ad    = $urandom_range(0, 3);
         bit          berr  = ($urandom_range(0, 7) == 0);
         bit          mis;
         logic [5:0]  exp_req;
         if ($urandom_range(0, 3) != 0) addr[1:0] = addr[1:0] & 2'(4 - nbytes(sz));
         mis = m_misaligned(sz, addr);
         run_op(op, addr, data, oreg, stl, ad, berr, rdata);
         $display("txn %0d op=%b addr=%h data=%h stall=%0d ack=%0d berr=%0d rsp=%b result=%h",
                  t, op, addr, data, stl, ad, berr, obs_rsp, obs_result);
         if (mis) begin
            n_cmp++;
            if (obs_rsp !== 5'b10100) begin n_fail++; $display("FAIL rnd_misalign: txn %0d got %b required 10100", t, obs_rsp); end
         end else begin
            exp_req = {1'b1, 1'b1, store, 1'b1, !store, 1'b1};
            n_cmp++;
            if ({obs_req, obs_sel, obs_adr, obs_wdat} !== {exp_req, m_sel(sz, addr), addr[31:2], m_wdat(sz, data)}) begin
               n_fail++;
               $display("FAIL rnd_request: txn %0d got ctl=%b sel=%b adr=%h wdat=%h required ctl=%b sel=%b adr=%h wdat=%h",
                        t, obs_req, obs_sel, obs_adr, obs_wdat, exp_req, m_sel(sz, addr), addr[31:2], m_wdat(sz, data));
            end
            n_cmp++;
            if (obs_hold_bad !== 0) begin n_fail++; $display("FAIL rnd_hold: txn %0d got %0d required 0", t, obs_hold_bad); end
            n_cmp++;
            if ({obs_rsp, obs_wreg} !== {1'b1, !store && !berr, berr, 2'b00, oreg}) begin
               n_fail++;
               $display("FAIL rnd_response: txn %0d got rsp=%b wreg=%h required rsp=%b wreg=%h",
                        t, obs_rsp, obs_wreg, {1'b1, !store && !berr, berr, 2'b00}, oreg);
            end
            if (!store && !berr) begin
               n_cmp++;
               if (obs_result !== m_result(sz, addr, rdata)) begin
                  n_fail++;
                  $display("FAIL rnd_result: txn %0d got %h required %h", t, obs_result, m_result(sz, addr, rdata));
               end
            end
         end
         n_cmp++;
         if (obs_after !== 3'b000) begin n_fail++; $display("FAIL rnd_single_pulse: txn %0d got %b required 000", t, obs_after); end
      end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_lanes();
      test_stall();
      test_bus_err();
      test_align_err();
      test_cpu_reset();
      test_lock();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
